// File: rtl/blob_pkg.sv
// Shared defaults, widths and FSM states for the blob-count read path.
package blob_pkg;

  localparam int IMG_COL_DEF = 640;
  localparam int IMG_ROW_DEF = 480;
  localparam int COUNT_W     = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRIME,
    S_STREAM,
    S_TAIL,
    S_WAIT,
    S_RELEASE
  } state_t;

endpackage

// File: rtl/blob_pix_binarize.sv
// Registered one-bit binarisation of a luma sample; output is forced low
// whenever the incoming sample is not marked valid.
module blob_pix_binarize
  import blob_pkg::*;
#(
  parameter int PIX_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  input  logic [PIX_W-1:0] i_data,
  input  logic [PIX_W-1:0] i_threshold,
  input  logic             i_invert,
  output logic             o_seq
);

  logic seq_d;
  logic seq_q;

  // Inverted polarity is simply the complement of the >= test (data < threshold).
  always_comb begin
    seq_d = i_valid & ((i_data >= i_threshold) ^ i_invert);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      seq_q <= 1'b0;
    end else begin
      seq_q <= seq_d;
    end
  end

  assign o_seq = seq_q;

endmodule

// File: rtl/blob_frame_streamer.sv
// Streams one stored luma frame as a thresholded bit stream to the blob counter
// and latches its result. Optional dark-object polarity: BLOB_STREAM_INVERT_EN.
module blob_frame_streamer
  import blob_pkg::*;
#(
  parameter int IMG_COL = IMG_COL_DEF,
  parameter int IMG_ROW = IMG_ROW_DEF,
  parameter int ADDR_W  = 19,
  parameter int PIX_W   = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic [PIX_W-1:0]   i_threshold,
`ifdef BLOB_STREAM_INVERT_EN
  input  logic               i_invert,
`endif
  output logic               o_rd_en,
  output logic [ADDR_W-1:0]  o_rd_addr,
  input  logic [PIX_W-1:0]   i_rd_data,
  output logic               o_valid,
  output logic               o_seq,
  input  logic               i_blob_valid,
  input  logic [COUNT_W-1:0] i_blob_count,
  output logic               o_busy,
  output logic               o_done,
  output logic [COUNT_W-1:0] o_count
);

  localparam int COL_W = (IMG_COL > 1) ? $clog2(IMG_COL) : 1;
  localparam int ROW_W = (IMG_ROW > 1) ? $clog2(IMG_ROW) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_COL - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_ROW - 1);

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic               issuedAll_q, issuedAll_d;
  logic [PIX_W-1:0]   thr_q, thr_d;
  logic               invert_q, invert_d;
  logic               valid_q, valid_d;
  logic               done_q, done_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               rdPend_q;
  logic               rdEn;
  logic               rdLast;

  assign rdLast = (row_q == ROW_LAST) && (col_q == COL_LAST);

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    col_d       = col_q;
    row_d       = row_q;
    issuedAll_d = issuedAll_q;
    thr_d       = thr_q;
    invert_d    = invert_q;
    valid_d     = valid_q;
    done_d      = 1'b0;
    count_d     = count_q;
    rdEn        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (i_start && !i_blob_valid) begin
          thr_d       = i_threshold;
`ifdef BLOB_STREAM_INVERT_EN
          invert_d    = i_invert;
`endif
          addr_d      = '0;
          col_d       = '0;
          row_d       = '0;
          issuedAll_d = 1'b0;
          state_d     = S_PRIME;
        end
      end
      S_PRIME: begin
        rdEn    = 1'b1;
        valid_d = 1'b1;
        state_d = S_STREAM;
      end
      // The last pixel's data arrives while its read is still pending; it is
      // registered at the same edge that moves us to S_TAIL.
      S_STREAM: begin
        rdEn = !issuedAll_q;
        if (issuedAll_q && rdPend_q) begin
          state_d = S_TAIL;
        end
      end
      S_TAIL: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (i_blob_valid) begin
          count_d = i_blob_count;
          done_d  = 1'b1;
          valid_d = 1'b0;
          state_d = S_RELEASE;
        end
      end
      S_RELEASE: begin
        if (!i_blob_valid) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (rdEn) begin
      if (rdLast) begin
        issuedAll_d = 1'b1;
      end else begin
        addr_d = addr_q + ADDR_W'(1);
        if (col_q == COL_LAST) begin
          col_d = '0;
          row_d = row_q + ROW_W'(1);
        end else begin
          col_d = col_q + COL_W'(1);
        end
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      col_q       <= '0;
      row_q       <= '0;
      issuedAll_q <= 1'b0;
      thr_q       <= '0;
      invert_q    <= 1'b0;
      valid_q     <= 1'b0;
      done_q      <= 1'b0;
      count_q     <= '0;
      rdPend_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      col_q       <= col_d;
      row_q       <= row_d;
      issuedAll_q <= issuedAll_d;
      thr_q       <= thr_d;
      invert_q    <= invert_d;
      valid_q     <= valid_d;
      done_q      <= done_d;
      count_q     <= count_d;
      rdPend_q    <= rdEn;
    end
  end

  blob_pix_binarize #(
    .PIX_W(PIX_W)
  ) u_binarize (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_valid    (rdPend_q),
    .i_data     (i_rd_data),
    .i_threshold(thr_q),
    .i_invert   (invert_q),
    .o_seq      (o_seq)
  );

  assign o_rd_en   = rdEn;
  assign o_rd_addr = addr_q;
  assign o_valid   = valid_q;
  assign o_busy    = (state_q != S_IDLE);
  assign o_done    = done_q;
  assign o_count   = count_q;

endmodule

// File: tb/tb_blob_frame_streamer.sv
// Scoreboard bench for blob_frame_streamer on an 8x4 frame with a behavioural
// RAM; define BLOB_STREAM_INVERT_EN to also exercise the dark-object polarity.
module tb_blob_frame_streamer;

  localparam int COLS = 8;
  localparam int ROWS = 4;
  localparam int N    = COLS * ROWS;
  localparam int AW   = 5;
`ifdef BLOB_STREAM_INVERT_EN
  localparam bit HAS_INV = 1'b1;
`else
  localparam bit HAS_INV = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset;
  logic          start;
  logic [7:0]    threshold;
`ifdef BLOB_STREAM_INVERT_EN
  logic          invertIn;
`endif
  logic          rdEn;
  logic [AW-1:0] rdAddr;
  logic [7:0]    rdData;
  logic          validOut;
  logic          seqOut;
  logic          blobValid;
  logic [7:0]    blobCount;
  logic          busy;
  logic          done;
  logic [7:0]    count;

  logic [7:0] mem [0:N-1];
  logic       expSeq[$];
  logic [7:0] expCount[$];
  int         checks = 0;
  int         errors = 0;

  always #5 clock = ~clock;

  blob_frame_streamer #(
    .IMG_COL(COLS),
    .IMG_ROW(ROWS),
    .ADDR_W (AW),
    .PIX_W  (8)
  ) dut (
    .i_clk       (clock),
    .i_rst       (reset),
    .i_start     (start),
    .i_threshold (threshold),
`ifdef BLOB_STREAM_INVERT_EN
    .i_invert    (invertIn),
`endif
    .o_rd_en     (rdEn),
    .o_rd_addr   (rdAddr),
    .i_rd_data   (rdData),
    .o_valid     (validOut),
    .o_seq       (seqOut),
    .i_blob_valid(blobValid),
    .i_blob_count(blobCount),
    .o_busy      (busy),
    .o_done      (done),
    .o_count     (count)
  );

  // Synchronous frame RAM: data one cycle after the read strobe.
  always @(posedge clock) begin
    if (rdEn) rdData <= mem[rdAddr];
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic reportFail(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s at %0t", name, $time);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Reference binarisation straight from the pixel rule.
  function automatic logic refBit(input logic [7:0] d, input logic [7:0] t, input logic inv);
    return inv ? (d < t) : (d >= t);
  endfunction

  task automatic waitIdle();
    int n = 0;
    while (busy && n < 200) begin
      tick(1);
      n++;
    end
    if (busy) reportFail("idle_timeout");
  endtask

  // Queue the expected pixel bits for the current RAM image, then pulse start.
  task automatic applyStimulus(input logic [7:0] thr, input logic inv);
    logic effInv;
    effInv = HAS_INV ? inv : 1'b0;
    for (int a = 0; a < N; a++) expSeq.push_back(refBit(mem[a], thr, effInv));
    threshold = thr;
`ifdef BLOB_STREAM_INVERT_EN
    invertIn = inv;
`endif
    start = 1'b1;
    tick(1);
    start = 1'b0;
    threshold = 8'($urandom);
`ifdef BLOB_STREAM_INVERT_EN
    invertIn = 1'($urandom);
`endif
  endtask

  task automatic runFrame(input logic [7:0] thr, input logic inv, input logic [7:0] cnt,
                          input int hold, input bit stray);
    bit gotDone;
    waitIdle();
    applyStimulus(thr, inv);
    tick(1);
    if (stray) begin
      tick(5);
      blobValid = 1'b1;
      tick(1);
      blobValid = 1'b0;
      tick(N + 2 + hold - 6);
    end else begin
      tick(N + 2 + hold);
    end
    checkOutput("wait_valid", int'(validOut), 1);
    checkOutput("wait_busy", int'(busy), 1);
    checkOutput("wait_seq", int'(seqOut), 0);
    expCount.push_back(cnt);
    blobCount = cnt;
    blobValid = 1'b1;
    gotDone = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      if (done) begin
        gotDone = 1'b1;
        break;
      end
    end
    if (!gotDone) reportFail("done_timeout");
    @(posedge clock);
    #1;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(3);
    checkOutput("release_busy", int'(busy), 1);
    checkOutput("release_valid", int'(validOut), 0);
    blobValid = 1'b0;
    tick(2);
    checkOutput("back_idle", int'(busy), 0);
  endtask

  // Monitor: pops expected pixel bits and counts as the DUT presents them.
  initial begin : monitor
    int cyc;
    bit prevValid;
    bit prevDone;
    cyc = -1;
    prevValid = 1'b0;
    prevDone = 1'b0;
    forever begin
      @(negedge clock);
      if (reset) begin
        expSeq.delete();
        expCount.delete();
        cyc = -1;
        prevValid = 1'b0;
        prevDone = 1'b0;
      end else begin
        if (prevDone) checkOutput("done_pulse", int'(done), 0);
        if (done) begin
          if (expCount.size() == 0) reportFail("done_unexpected");
          else checkOutput("count", int'(count), int'(expCount.pop_front()));
          checkOutput("valid_drop", int'(validOut), 0);
        end
        if (validOut) begin
          cyc = prevValid ? cyc + 1 : 0;
          if (cyc >= 1 && cyc <= N) begin
            if (expSeq.size() == 0) reportFail("seq_unexpected");
            else checkOutput($sformatf("seq_px%0d", cyc - 1), int'(seqOut), int'(expSeq.pop_front()));
          end else if (cyc > N) begin
            checkOutput("seq_tail", int'(seqOut), 0);
          end
          if (cyc <= N - 2) begin
            checkOutput("rd_en", int'(rdEn), 1);
            checkOutput("rd_addr", int'(rdAddr), cyc + 1);
          end else begin
            checkOutput("rd_en_off", int'(rdEn), 0);
          end
          checkOutput("busy_frame", int'(busy), 1);
        end else begin
          if (prevValid) checkOutput("frame_len", expSeq.size(), 0);
          if (rdEn) begin
            checkOutput("prime_addr", int'(rdAddr), 0);
            checkOutput("prime_busy", int'(busy), 1);
          end
        end
        prevValid = validOut;
        prevDone = done;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    reset = 1'b1;
    start = 1'b0;
    threshold = 8'd0;
`ifdef BLOB_STREAM_INVERT_EN
    invertIn = 1'b0;
`endif
    blobValid = 1'b0;
    blobCount = 8'd0;
    for (int a = 0; a < N; a++) mem[a] = 8'(a * 8);
    tick(3);
    checkOutput("rst_valid", int'(validOut), 0);
    checkOutput("rst_seq", int'(seqOut), 0);
    checkOutput("rst_rd_en", int'(rdEn), 0);
    checkOutput("rst_rd_addr", int'(rdAddr), 0);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_done", int'(done), 0);
    checkOutput("rst_count", int'(count), 0);
    reset = 1'b0;
    tick(2);

    // Ramp frame, long wait before the counter answers.
    runFrame(8'd128, 1'b0, 8'd5, 50, 1'b0);

    // Start while the counter still shows a result is ignored in idle too.
    blobValid = 1'b1;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(3);
    checkOutput("idle_start_ignored", int'(busy), 0);
    blobValid = 1'b0;
    tick(1);

    // Abort mid-frame with reset on a frame of ones.
    for (int a = 0; a < N; a++) mem[a] = 8'd255;
    applyStimulus(8'd0, 1'b0);
    tick(11);
    #1;
    reset = 1'b1;
    #1;
    checkOutput("abort_valid", int'(validOut), 0);
    checkOutput("abort_seq", int'(seqOut), 0);
    checkOutput("abort_rd_en", int'(rdEn), 0);
    checkOutput("abort_busy", int'(busy), 0);
    checkOutput("abort_done", int'(done), 0);
    checkOutput("abort_count", int'(count), 0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    tick(2);

    for (int a = 0; a < N; a++) mem[a] = 8'(a * 8);
    runFrame(8'd128, 1'b0, 8'd17, 3, 1'b0);

    for (int a = 0; a < N; a++) mem[a] = 8'd255;
    runFrame(8'd0, 1'b0, 8'd1, 2, 1'b0);
    runFrame(8'd255, 1'b0, 8'd2, 2, 1'b0);
    for (int a = 0; a < N; a++) mem[a] = 8'd254;
    runFrame(8'd255, 1'b0, 8'd0, 2, 1'b0);

    for (int f = 0; f < 6; f++) begin
      for (int a = 0; a < N; a++) mem[a] = 8'($urandom);
      runFrame(8'($urandom), 1'($urandom), 8'($urandom), $urandom_range(0, 5), (f % 2) == 1);
    end

`ifdef BLOB_STREAM_INVERT_EN
    for (int a = 0; a < N; a++) mem[a] = 8'(a * 8);
    runFrame(8'd128, 1'b1, 8'd9, 4, 1'b0);
`endif

    waitIdle();
    tick(3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
